rgb_pwm_sequencer: RTL

Drives the three PWM inputs of the iCE40 `SB_RGBA_DRV` LED driver from a programmable 4-step colour sequence, with a host override channel arbitrated against the sequence. Sits between the `SB_HFOSC`-clocked fabric and the RGB driver primitive, replacing static PWM tie-offs. All colour changes, grants and state transitions happen only on PWM period boundaries, so the LED never sees a truncated or glitched period.

---
 rtl/rgb_seq_pkg.sv | 28 ++
 rtl/rgb_pwm_chan.sv | 41 ++++
 rtl/rgb_pwm_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/rgb_seq_pkg.sv
// Shared state encoding, default sizes, colour struct and gamma helper for the RGB sequencer.
// Gamma correction is compiled in only when RGB_SEQ_GAMMA_EN is defined.
package rgb_seq_pkg;

   localparam int CNT_W_DEF = 8;
   localparam int STEPS_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      OVR  = 2'd2
   } state_t;

   typedef struct packed {
      logic [CNT_W_DEF-1:0] r;
      logic [CNT_W_DEF-1:0] g;
      logic [CNT_W_DEF-1:0] b;
   } rgb_t;

   // ((d+1)*d) >> w keeps 0 at 0 and full scale at full scale.
   function automatic logic [15:0] gamma(input logic [15:0] d, input int w);
      logic [31:0] p;
      p = ({16'd0, d} + 32'd1) * {16'd0, d};
      p = p >> w;
      return p[15:0];
   endfunction

endpackage

// File: rtl/rgb_pwm_chan.sv
// One PWM channel: duty register loaded on the period boundary, optional gamma
// (RGB_SEQ_GAMMA_EN), and a registered comparator so pwm_o lags cnt_i by one cycle.
module rgb_pwm_chan
   import rgb_seq_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] duty_i,
   input  logic [CNT_W-1:0] cnt_i,
   output logic             pwm_o
);

   logic [CNT_W-1:0] duty_q, duty_d;
   logic             pwm_q;

`ifdef RGB_SEQ_GAMMA_EN
   logic [15:0] gam;
   always_comb begin
      gam    = gamma(16'(duty_i), CNT_W);
      duty_d = gam[CNT_W-1:0];
   end
`else
   assign duty_d = duty_i;
`endif

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         duty_q <= '0;
         pwm_q  <= 1'b0;
      end else begin
         if (load_i) duty_q <= duty_d;
         pwm_q <= (cnt_i < duty_q);
      end
   end

   assign pwm_o = pwm_q;

endmodule

// File: rtl/rgb_pwm_sequencer.sv
// 4-step RGB colour sequencer with host override for SB_RGBA_DRV; every state, step and
// duty change lands on the PWM period boundary. Gamma option: RGB_SEQ_GAMMA_EN.
module rgb_pwm_sequencer
   import rgb_seq_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int STEPS   = STEPS_DEF,
   parameter int DWELL_W = 16
) (
   input  logic                     int_osc,
   input  logic                     rst_n,
   input  logic                     cfg_we,
   input  logic [$clog2(STEPS)-1:0] cfg_idx,
   input  logic [3*CNT_W-1:0]       cfg_rgb,
   input  logic [DWELL_W-1:0]       dwell,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     ovr_req,
   input  logic [3*CNT_W-1:0]       ovr_rgb,
   output logic                     ovr_gnt,
   output logic                     pwm_r,
   output logic                     pwm_g,
   output logic                     pwm_b,
   output logic                     busy,
   output logic [$clog2(STEPS)-1:0] step,
   output logic                     period_end
);

   localparam int IDX_W = $clog2(STEPS);
   localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

   state_t             state_q, state_d, resume_q, resume_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   step_q, step_d;
   logic [DWELL_W-1:0] dcnt_q, dcnt_d, dlim_q, dlim_d, dwell_eff;
   logic [DWELL_W:0]   dcnt_inc;
   logic               start_pend_q, start_pend_d, stop_pend_q, stop_pend_d;
   logic [3*CNT_W-1:0] table_q [STEPS];
   logic [3*CNT_W-1:0] duty_src;
   logic               at_b;

   assign at_b      = (cnt_q == CNT_LAST);
   assign cnt_d     = at_b ? '0 : cnt_q + CNT_W'(1);
   assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
   assign dcnt_inc  = {1'b0, dcnt_q} + (DWELL_W+1)'(1);

   always_ff @(posedge int_osc or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         resume_q     <= IDLE;
         cnt_q        <= '0;
         step_q       <= '0;
         dcnt_q       <= '0;
         dlim_q       <= '0;
         start_pend_q <= 1'b0;
         stop_pend_q  <= 1'b0;
         for (int i = 0; i < STEPS; i++) table_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         resume_q     <= resume_d;
         cnt_q        <= cnt_d;
         step_q       <= step_d;
         dcnt_q       <= dcnt_d;
         dlim_q       <= dlim_d;
         start_pend_q <= start_pend_d;
         stop_pend_q  <= stop_pend_d;
         if (cfg_we) table_q[cfg_idx] <= cfg_rgb;
      end
   end

   // Pending flags include this cycle's pulse so a pulse on the boundary cycle counts.
   always_comb begin
      state_d      = state_q;
      resume_d     = resume_q;
      step_d       = step_q;
      dcnt_d       = dcnt_q;
      dlim_d       = dlim_q;
      start_pend_d = start_pend_q | start;
      stop_pend_d  = stop_pend_q | stop;
      if (at_b) begin
         if (ovr_req && state_q != OVR) begin
            state_d  = OVR;
            resume_d = (state_q == RUN) ? RUN : IDLE;
         end else if (state_q == OVR && !ovr_req) begin
            state_d = resume_q;
         end else if (stop_pend_d) begin
            start_pend_d = 1'b0;
            stop_pend_d  = 1'b0;
            if (state_q == OVR) resume_d = IDLE;
            else                state_d  = IDLE;
         end else if (start_pend_d && state_q == IDLE) begin
            state_d      = RUN;
            step_d       = '0;
            dcnt_d       = '0;
            dlim_d       = dwell_eff;
            start_pend_d = 1'b0;
         end else if (state_q == RUN) begin
            start_pend_d = 1'b0;
            if (dcnt_inc == {1'b0, dlim_q}) begin
               step_d = step_q + IDX_W'(1);
               dcnt_d = '0;
               dlim_d = dwell_eff;
            end else begin
               dcnt_d = dcnt_inc[DWELL_W-1:0];
            end
         end
      end
   end

   always_comb begin
      duty_src = '0;
      case (state_d)
         RUN:     duty_src = table_q[step_d];
         OVR:     duty_src = ovr_rgb;
         default: duty_src = '0;
      endcase
   end

   rgb_pwm_chan #(.CNT_W(CNT_W)) u_chan_r (
      .clk_i(int_osc), .rst_n_i(rst_n), .load_i(at_b),
      .duty_i(duty_src[2*CNT_W +: CNT_W]), .cnt_i(cnt_q), .pwm_o(pwm_r)
   );
   rgb_pwm_chan #(.CNT_W(CNT_W)) u_chan_g (
      .clk_i(int_osc), .rst_n_i(rst_n), .load_i(at_b),
      .duty_i(duty_src[CNT_W +: CNT_W]), .cnt_i(cnt_q), .pwm_o(pwm_g)
   );
   rgb_pwm_chan #(.CNT_W(CNT_W)) u_chan_b (
      .clk_i(int_osc), .rst_n_i(rst_n), .load_i(at_b),
      .duty_i(duty_src[0 +: CNT_W]), .cnt_i(cnt_q), .pwm_o(pwm_b)
   );

   assign busy       = (state_q != IDLE);
   assign ovr_gnt    = (state_q == OVR);
   assign step       = step_q;
   assign period_end = at_b;

endmodule
